// File: rtl/avr_asm_pkg.sv
// Shared types and constants for the AVR instruction encoder: mnemonics, error causes,
// opcode base words, SREG flag letters and field-packing helpers.
package avr_asm_pkg;

    typedef enum logic [5:0] {
        OP_NOP, OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_AND, OP_OR, OP_EOR, OP_MOV, OP_CP, OP_CPC,
        OP_MOVW, OP_LDI, OP_CPI, OP_SUBI, OP_SBCI, OP_ANDI, OP_ORI, OP_ADIW, OP_SBIW,
        OP_IN, OP_OUT, OP_SBI, OP_CBI, OP_RJMP, OP_RCALL, OP_BRBS, OP_BRBC, OP_BSET, OP_BCLR,
        OP_JMP, OP_CALL, OP_LDS, OP_STS, OP_RET,
        OP_LSL, OP_ROL, OP_TST, OP_CLR, OP_SEF, OP_CLF, OP_BRFS, OP_BRFC
    } op_t;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_RANGE_RD  = 3'd1,
        ERR_RANGE_K   = 3'd2,
        ERR_RANGE_OFS = 3'd3,
        ERR_ODD_REG   = 3'd4,
        ERR_BAD_OP    = 3'd5
    } err_t;

    localparam logic [15:0] OPC_ADD   = 16'h0C00;
    localparam logic [15:0] OPC_ADC   = 16'h1C00;
    localparam logic [15:0] OPC_SUB   = 16'h1800;
    localparam logic [15:0] OPC_SBC   = 16'h0800;
    localparam logic [15:0] OPC_AND   = 16'h2000;
    localparam logic [15:0] OPC_OR    = 16'h2800;
    localparam logic [15:0] OPC_EOR   = 16'h2400;
    localparam logic [15:0] OPC_MOV   = 16'h2C00;
    localparam logic [15:0] OPC_CP    = 16'h1400;
    localparam logic [15:0] OPC_CPC   = 16'h0400;
    localparam logic [15:0] OPC_MOVW  = 16'h0100;
    localparam logic [15:0] OPC_LDI   = 16'hE000;
    localparam logic [15:0] OPC_CPI   = 16'h3000;
    localparam logic [15:0] OPC_SUBI  = 16'h5000;
    localparam logic [15:0] OPC_SBCI  = 16'h4000;
    localparam logic [15:0] OPC_ANDI  = 16'h7000;
    localparam logic [15:0] OPC_ORI   = 16'h6000;
    localparam logic [15:0] OPC_ADIW  = 16'h9600;
    localparam logic [15:0] OPC_SBIW  = 16'h9700;
    localparam logic [15:0] OPC_IN    = 16'hB000;
    localparam logic [15:0] OPC_OUT   = 16'hB800;
    localparam logic [15:0] OPC_SBI   = 16'h9A00;
    localparam logic [15:0] OPC_CBI   = 16'h9800;
    localparam logic [15:0] OPC_RJMP  = 16'hC000;
    localparam logic [15:0] OPC_RCALL = 16'hD000;
    localparam logic [15:0] OPC_BRBS  = 16'hF000;
    localparam logic [15:0] OPC_BRBC  = 16'hF400;
    localparam logic [15:0] OPC_BSET  = 16'h9408;
    localparam logic [15:0] OPC_BCLR  = 16'h9488;
    localparam logic [15:0] OPC_JMP   = 16'h940C;
    localparam logic [15:0] OPC_CALL  = 16'h940E;
    localparam logic [15:0] OPC_LDS   = 16'h9000;
    localparam logic [15:0] OPC_STS   = 16'h9200;
    localparam logic [15:0] OPC_RET   = 16'h9508;

    // SREG bit n carries the letter in byte n: C Z N V S H T I
    localparam logic [63:0] SREG_LETTERS = "ITHSVNZC";

    function automatic logic [7:0] flag_letter(input logic [2:0] b);
        return SREG_LETTERS[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [15:0] enc_rr(input logic [15:0] base, input logic [4:0] d,
                                           input logic [4:0] r);
        return base | {6'd0, r[4], d, r[3:0]};
    endfunction

    function automatic logic [15:0] enc_imm(input logic [15:0] base, input logic [3:0] d,
                                            input logic [7:0] k);
        return base | {4'd0, k[7:4], d, k[3:0]};
    endfunction

endpackage

// File: rtl/avr_asm_enc_word.sv
// Combinational AVR word generation and legality check for one request.
// Define AVR_ASM_ALIAS_EN to accept the lsl/rol/tst/clr, se<f>/cl<f> and br<f>s/br<f>c aliases.
module avr_asm_enc_word
    import avr_asm_pkg::*;
(
    input  op_t         op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rr,
    input  logic [2:0]  b,
    input  logic [21:0] k,
    output logic [15:0] w0,
    output logic [15:0] w1,
    output logic        two_word,
    output err_t        err_code
);

    logic k_gt31_s;
    logic k_gt63_s;
    logic k_gt255_s;
    logic ofs12_ok_s;
    logic ofs7_ok_s;
    err_t imm_err_s;
    err_t wide_err_s;

    assign k_gt31_s   = |k[21:5];
    assign k_gt63_s   = |k[21:6];
    assign k_gt255_s  = |k[21:8];
    // Signed offset fits when every bit above the field matches the field's sign bit
    assign ofs12_ok_s = (&k[21:11]) || !(|k[21:11]);
    assign ofs7_ok_s  = (&k[21:6]) || !(|k[21:6]);
    assign imm_err_s  = !rd[4] ? ERR_RANGE_RD : (k_gt255_s ? ERR_RANGE_K : ERR_NONE);
    assign wide_err_s = (rd[4:3] != 2'b11 || rd[0]) ? ERR_RANGE_RD
                      : (k_gt63_s ? ERR_RANGE_K : ERR_NONE);

    // Opcode field packing and range checks per mnemonic
    always_comb begin
        w0       = 16'h0000;
        w1       = 16'h0000;
        two_word = 1'b0;
        err_code = ERR_NONE;
        case (op)
            OP_NOP:  w0 = 16'h0000;
            OP_RET:  w0 = OPC_RET;
            OP_ADD:  w0 = enc_rr(OPC_ADD, rd, rr);
            OP_ADC:  w0 = enc_rr(OPC_ADC, rd, rr);
            OP_SUB:  w0 = enc_rr(OPC_SUB, rd, rr);
            OP_SBC:  w0 = enc_rr(OPC_SBC, rd, rr);
            OP_AND:  w0 = enc_rr(OPC_AND, rd, rr);
            OP_OR:   w0 = enc_rr(OPC_OR, rd, rr);
            OP_EOR:  w0 = enc_rr(OPC_EOR, rd, rr);
            OP_MOV:  w0 = enc_rr(OPC_MOV, rd, rr);
            OP_CP:   w0 = enc_rr(OPC_CP, rd, rr);
            OP_CPC:  w0 = enc_rr(OPC_CPC, rd, rr);
            OP_MOVW: begin
                w0       = OPC_MOVW | {8'h00, rd[4:1], rr[4:1]};
                err_code = (rd[0] || rr[0]) ? ERR_ODD_REG : ERR_NONE;
            end
            OP_LDI:  begin w0 = enc_imm(OPC_LDI, rd[3:0], k[7:0]);  err_code = imm_err_s; end
            OP_CPI:  begin w0 = enc_imm(OPC_CPI, rd[3:0], k[7:0]);  err_code = imm_err_s; end
            OP_SUBI: begin w0 = enc_imm(OPC_SUBI, rd[3:0], k[7:0]); err_code = imm_err_s; end
            OP_SBCI: begin w0 = enc_imm(OPC_SBCI, rd[3:0], k[7:0]); err_code = imm_err_s; end
            OP_ANDI: begin w0 = enc_imm(OPC_ANDI, rd[3:0], k[7:0]); err_code = imm_err_s; end
            OP_ORI:  begin w0 = enc_imm(OPC_ORI, rd[3:0], k[7:0]);  err_code = imm_err_s; end
            OP_ADIW: begin
                w0       = OPC_ADIW | {8'h00, k[5:4], rd[2:1], k[3:0]};
                err_code = wide_err_s;
            end
            OP_SBIW: begin
                w0       = OPC_SBIW | {8'h00, k[5:4], rd[2:1], k[3:0]};
                err_code = wide_err_s;
            end
            OP_IN: begin
                w0       = OPC_IN | {5'd0, k[5:4], rd, k[3:0]};
                err_code = k_gt63_s ? ERR_RANGE_K : ERR_NONE;
            end
            OP_OUT: begin
                w0       = OPC_OUT | {5'd0, k[5:4], rr, k[3:0]};
                err_code = k_gt63_s ? ERR_RANGE_K : ERR_NONE;
            end
            OP_SBI: begin
                w0       = OPC_SBI | {8'h00, k[4:0], b};
                err_code = k_gt31_s ? ERR_RANGE_K : ERR_NONE;
            end
            OP_CBI: begin
                w0       = OPC_CBI | {8'h00, k[4:0], b};
                err_code = k_gt31_s ? ERR_RANGE_K : ERR_NONE;
            end
            OP_RJMP: begin
                w0       = OPC_RJMP | {4'h0, k[11:0]};
                err_code = ofs12_ok_s ? ERR_NONE : ERR_RANGE_OFS;
            end
            OP_RCALL: begin
                w0       = OPC_RCALL | {4'h0, k[11:0]};
                err_code = ofs12_ok_s ? ERR_NONE : ERR_RANGE_OFS;
            end
            OP_BRBS: begin
                w0       = OPC_BRBS | {6'd0, k[6:0], b};
                err_code = ofs7_ok_s ? ERR_NONE : ERR_RANGE_OFS;
            end
            OP_BRBC: begin
                w0       = OPC_BRBC | {6'd0, k[6:0], b};
                err_code = ofs7_ok_s ? ERR_NONE : ERR_RANGE_OFS;
            end
            OP_BSET: w0 = OPC_BSET | {9'd0, b, 4'h0};
            OP_BCLR: w0 = OPC_BCLR | {9'd0, b, 4'h0};
            OP_JMP: begin
                w0       = OPC_JMP | {7'd0, k[21:17], 3'd0, k[16]};
                w1       = k[15:0];
                two_word = 1'b1;
            end
            OP_CALL: begin
                w0       = OPC_CALL | {7'd0, k[21:17], 3'd0, k[16]};
                w1       = k[15:0];
                two_word = 1'b1;
            end
            OP_LDS: begin
                w0       = OPC_LDS | {7'd0, rd, 4'h0};
                w1       = k[15:0];
                two_word = 1'b1;
            end
            OP_STS: begin
                w0       = OPC_STS | {7'd0, rr, 4'h0};
                w1       = k[15:0];
                two_word = 1'b1;
            end
`ifdef AVR_ASM_ALIAS_EN
            OP_LSL: w0 = enc_rr(OPC_ADD, rd, rd);
            OP_ROL: w0 = enc_rr(OPC_ADC, rd, rd);
            OP_TST: w0 = enc_rr(OPC_AND, rd, rd);
            OP_CLR: w0 = enc_rr(OPC_EOR, rd, rd);
            OP_SEF: w0 = OPC_BSET | {9'd0, b, 4'h0};
            OP_CLF: w0 = OPC_BCLR | {9'd0, b, 4'h0};
            OP_BRFS: begin
                w0       = OPC_BRBS | {6'd0, k[6:0], b};
                err_code = ofs7_ok_s ? ERR_NONE : ERR_RANGE_OFS;
            end
            OP_BRFC: begin
                w0       = OPC_BRBC | {6'd0, k[6:0], b};
                err_code = ofs7_ok_s ? ERR_NONE : ERR_RANGE_OFS;
            end
`endif
            default: err_code = ERR_BAD_OP;
        endcase
    end

endmodule

// File: rtl/avr_asm_enc.sv
// AVR instruction encoder: request handshake, word sequencing FSM and word address counter.
// Alias mnemonics are accepted only when AVR_ASM_ALIAS_EN is defined.
module avr_asm_enc
    import avr_asm_pkg::*;
#(
    parameter int PAW  = 16,
    parameter int BASE = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  op_t            in_op,
    input  logic [4:0]     in_rd,
    input  logic [4:0]     in_rr,
    input  logic [2:0]     in_b,
    input  logic [21:0]    in_k,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [15:0]    out_code,
    output logic [PAW-1:0] out_addr,
    output logic           out_last,
    output logic           err,
    output err_t           err_code
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        W0   = 2'd1,
        W1   = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_s;
    logic [15:0]    w0_s;
    logic [15:0]    w1_s;
    logic           two_s;
    err_t           ecode_s;
    logic           legal_s;
    logic           accept_s;
    logic           out_hs_s;
    logic [15:0]    code_r;
    logic [15:0]    w1_r;
    logic           last_r;
    logic           two_r;
    logic           run_r;
    logic           err_r;
    err_t           err_code_r;
    logic [PAW-1:0] addr_r;

    avr_asm_enc_word u_word (
        .op       (in_op),
        .rd       (in_rd),
        .rr       (in_rr),
        .b        (in_b),
        .k        (in_k),
        .w0       (w0_s),
        .w1       (w1_s),
        .two_word (two_s),
        .err_code (ecode_s)
    );

    assign legal_s   = (ecode_s == ERR_NONE);
    assign accept_s  = in_valid && in_ready;
    assign out_valid = (state_r != IDLE);
    assign out_hs_s  = out_valid && out_ready;
    assign out_code  = code_r;
    assign out_addr  = addr_r;
    assign out_last  = last_r;
    assign err       = err_r;
    assign err_code  = err_code_r;

    // A new request may enter only when the held word is the instruction's last and leaves now
    always_comb begin
        in_ready = 1'b0;
        if (!run_r) begin
            in_ready = 1'b0;
        end else if (state_r == IDLE) begin
            in_ready = 1'b1;
        end else begin
            in_ready = out_ready && last_r;
        end
    end

    // Next-state logic for word sequencing
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s && legal_s) state_s = W0;
                else                     state_s = IDLE;
            end
            W0: begin
                if (!out_hs_s)                state_s = W0;
                else if (two_r)               state_s = W1;
                else if (accept_s && legal_s) state_s = W0;
                else                          state_s = IDLE;
            end
            W1: begin
                if (!out_hs_s)                state_s = W1;
                else if (accept_s && legal_s) state_s = W0;
                else                          state_s = IDLE;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_s;
    end

    // Held words, address counter and error pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            code_r     <= 16'h0000;
            w1_r       <= 16'h0000;
            last_r     <= 1'b0;
            two_r      <= 1'b0;
            run_r      <= 1'b0;
            err_r      <= 1'b0;
            err_code_r <= ERR_NONE;
            addr_r     <= PAW'(BASE);
        end else begin
            run_r      <= 1'b1;
            err_r      <= 1'b0;
            err_code_r <= ERR_NONE;
            if (out_hs_s) addr_r <= addr_r + {{(PAW-1){1'b0}}, 1'b1};
            if (accept_s) begin
                if (legal_s) begin
                    code_r <= w0_s;
                    w1_r   <= w1_s;
                    two_r  <= two_s;
                    last_r <= !two_s;
                end else begin
                    err_r      <= 1'b1;
                    err_code_r <= ecode_s;
                end
            end else if (out_hs_s && state_r == W0 && two_r) begin
                code_r <= w1_r;
                last_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_avr_asm_enc.sv
// Scoreboard bench for avr_asm_enc: a wide-address instance and a PAW=4/BASE=15 instance
// receive the same requests; monitors pop expected words and errors as the DUTs emit them.
module tb_avr_asm_enc;
    import avr_asm_pkg::*;

    localparam int A_PAW  = 16;
    localparam int A_BASE = 64;
    localparam int B_PAW  = 4;
    localparam int B_BASE = 15;

    typedef struct packed {
        logic [15:0] code;
        logic [15:0] addr;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    op_t         in_op = OP_NOP;
    logic [4:0]  in_rd = 5'd0;
    logic [4:0]  in_rr = 5'd0;
    logic [2:0]  in_b = 3'd0;
    logic [21:0] in_k = 22'd0;

    logic              in_ready_a, out_valid_a, out_last_a, err_a;
    logic [15:0]       out_code_a;
    logic [A_PAW-1:0]  out_addr_a;
    err_t              err_code_a;
    logic              in_ready_b, out_valid_b, out_last_b, err_b;
    logic [15:0]       out_code_b;
    logic [B_PAW-1:0]  out_addr_b;
    err_t              err_code_b;

    exp_t        qa[$];
    exp_t        qb[$];
    err_t        ea[$];
    err_t        eb[$];
    int          hs_cyc[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [15:0] exp_a;
    logic [3:0]  exp_b;

    avr_asm_enc #(.PAW(A_PAW), .BASE(A_BASE)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_op(in_op), .in_rd(in_rd), .in_rr(in_rr), .in_b(in_b), .in_k(in_k),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_code(out_code_a),
        .out_addr(out_addr_a), .out_last(out_last_a), .err(err_a), .err_code(err_code_a)
    );

    avr_asm_enc #(.PAW(B_PAW), .BASE(B_BASE)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_op(in_op), .in_rd(in_rd), .in_rr(in_rr), .in_b(in_b), .in_k(in_k),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_code(out_code_b),
        .out_addr(out_addr_b), .out_last(out_last_b), .err(err_b), .err_code(err_code_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endfunction

    // Monitor for the wide instance
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (out_valid_a && out_ready) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_word", 32'(out_code_a), 32'hFFFF_FFFF);
            end else begin
                e = qa.pop_front();
                chk("a_code", 32'(out_code_a), 32'(e.code));
                chk("a_addr", 32'(out_addr_a), 32'(e.addr));
                chk("a_last", 32'(out_last_a), 32'(e.last));
                hs_cyc.push_back(cyc);
            end
        end
        if (err_a) begin
            if (ea.size() == 0) chk("a_unexpected_err", 32'(err_code_a), 32'hFFFF_FFFF);
            else                chk("a_err_code", 32'(err_code_a), 32'(ea.pop_front()));
        end
    end

    // Monitor for the wrapping-address instance
    always @(negedge clk) begin : mon_b
        exp_t e;
        if (out_valid_b && out_ready) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_word", 32'(out_code_b), 32'hFFFF_FFFF);
            end else begin
                e = qb.pop_front();
                chk("b_code", 32'(out_code_b), 32'(e.code));
                chk("b_addr", 32'(out_addr_b), 32'(e.addr[3:0]));
                chk("b_last", 32'(out_last_b), 32'(e.last));
            end
        end
        if (err_b) begin
            if (eb.size() == 0) chk("b_unexpected_err", 32'(err_code_b), 32'hFFFF_FFFF);
            else                chk("b_err_code", 32'(err_code_b), 32'(eb.pop_front()));
        end
    end

    task automatic push_word(input logic [15:0] code, input logic last);
        qa.push_back('{code: code, addr: exp_a, last: last});
        qb.push_back('{code: code, addr: {12'h000, exp_b}, last: last});
        exp_a = exp_a + 16'd1;
        exp_b = exp_b + 4'd1;
    endtask

    task automatic push_err(input err_t code);
        ea.push_back(code);
        eb.push_back(code);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input op_t op, input logic [4:0] rd, input logic [4:0] rr,
                        input logic [2:0] b, input logic [21:0] k);
        int n;
        in_op = op; in_rd = rd; in_rr = rr; in_b = b; in_k = k;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready_a && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("accept_in_time", 32'(in_ready_a), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int n0;
        exp_a = 16'(A_BASE);
        exp_b = 4'(B_BASE);

        // Reset state
        rst_n = 1'b0;
        tick(3);
        chk("rst_out_valid", 32'(out_valid_a), 32'd0);
        chk("rst_out_last", 32'(out_last_a), 32'd0);
        chk("rst_out_code", 32'(out_code_a), 32'd0);
        chk("rst_err", 32'(err_a), 32'd0);
        chk("rst_err_code", 32'(err_code_a), 32'(ERR_NONE));
        chk("rst_out_addr", 32'(out_addr_a), 32'(A_BASE));
        chk("rst_in_ready", 32'(in_ready_a), 32'd0);
        chk("rst_b_addr", 32'(out_addr_b), 32'(B_BASE));
        rst_n = 1'b1;
        tick(1);
        chk("ready_after_rst", 32'(in_ready_a), 32'd1);

        // ldi r16,0xAB: one word, presented one cycle after accept
        out_ready = 1'b1;
        push_word(16'hEA0B, 1'b1);
        send(OP_LDI, 5'd16, 5'd0, 3'd0, 22'h0000AB);
        chk("ldi_latency_valid", 32'(out_valid_a), 32'd1);
        chk("ldi_latency_code", 32'(out_code_a), 32'h0000_EA0B);
        tick(1);

        // jmp 0x1234 with a 3-cycle stall on the second word
        out_ready = 1'b0;
        push_word(16'h940C, 1'b0);
        push_word(16'h1234, 1'b1);
        send(OP_JMP, 5'd0, 5'd0, 3'd0, 22'h001234);
        chk("jmp_w0_ready", 32'(in_ready_a), 32'd0);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("jmp_stall_valid", 32'(out_valid_a), 32'd1);
            chk("jmp_stall_code", 32'(out_code_a), 32'h0000_1234);
            chk("jmp_stall_addr", 32'(out_addr_a), 32'(A_BASE + 2));
            chk("jmp_stall_last", 32'(out_last_a), 32'd1);
            chk("jmp_stall_ready", 32'(in_ready_a), 32'd0);
        end
        out_ready = 1'b1;
        tick(1);
        chk("jmp_done_idle", 32'(out_valid_a), 32'd0);

        // add r1,r2 then rjmp -1 streamed in consecutive cycles
        n0 = hs_cyc.size();
        push_word(16'h0C12, 1'b1);
        push_word(16'hCFFF, 1'b1);
        send(OP_ADD, 5'd1, 5'd2, 3'd0, 22'd0);
        send(OP_RJMP, 5'd0, 5'd0, 3'd0, 22'h3FFFFF);
        tick(2);
        chk("stream_word_count", 32'(hs_cyc.size() - n0), 32'd2);
        chk("stream_consecutive", 32'(hs_cyc[n0 + 1] - hs_cyc[n0]), 32'd1);

        // ldi r15: one-cycle error, next legal word reuses the address
        push_err(ERR_RANGE_RD);
        send(OP_LDI, 5'd15, 5'd0, 3'd0, 22'h000001);
        chk("ldi_r15_no_word", 32'(out_valid_a), 32'd0);
        chk("ldi_r15_err", 32'(err_a), 32'd1);
        tick(1);
        chk("ldi_r15_err_pulse", 32'(err_a), 32'd0);
        push_word(16'h5112, 1'b1);
        send(OP_SUBI, 5'd17, 5'd0, 3'd0, 22'h000012);

        // clr r5 depends on the alias build
`ifdef AVR_ASM_ALIAS_EN
        push_word(16'h2455, 1'b1);
`else
        push_err(ERR_BAD_OP);
`endif
        send(OP_CLR, 5'd5, 5'd0, 3'd0, 22'd0);

        // Range boundaries and other encodings
        push_err(ERR_RANGE_OFS);    send(OP_RJMP, 5'd0, 5'd0, 3'd0, 22'd2048);
        push_word(16'hC800, 1'b1);  send(OP_RJMP, 5'd0, 5'd0, 3'd0, 22'h3FF800);
        push_word(16'hF1F9, 1'b1);  send(OP_BRBS, 5'd0, 5'd0, 3'd1, 22'd63);
        push_err(ERR_RANGE_OFS);    send(OP_BRBC, 5'd0, 5'd0, 3'd1, 22'h3FFFBF);
        push_err(ERR_RANGE_RD);     send(OP_ADIW, 5'd23, 5'd0, 3'd0, 22'd1);
        push_word(16'h96FF, 1'b1);  send(OP_ADIW, 5'd30, 5'd0, 3'd0, 22'd63);
        push_err(ERR_RANGE_K);      send(OP_ADIW, 5'd24, 5'd0, 3'd0, 22'd64);
        push_err(ERR_ODD_REG);      send(OP_MOVW, 5'd3, 5'd4, 3'd0, 22'd0);
        push_word(16'h0112, 1'b1);  send(OP_MOVW, 5'd2, 5'd4, 3'd0, 22'd0);
        push_err(ERR_BAD_OP);       send(op_t'(6'd63), 5'd0, 5'd0, 3'd0, 22'd0);
        push_err(ERR_RANGE_K);      send(OP_SBI, 5'd0, 5'd0, 3'd0, 22'd32);
        push_word(16'h9AFF, 1'b1);  send(OP_SBI, 5'd0, 5'd0, 3'd7, 22'd31);
        push_word(16'hEFFF, 1'b1);  send(OP_LDI, 5'd31, 5'd0, 3'd0, 22'd255);
        push_err(ERR_RANGE_K);      send(OP_ANDI, 5'd20, 5'd0, 3'd0, 22'd256);
        push_word(16'h95FF, 1'b0);
        push_word(16'h0001, 1'b1);  send(OP_CALL, 5'd0, 5'd0, 3'd0, 22'h3F0001);
        push_word(16'h9050, 1'b0);
        push_word(16'hBEEF, 1'b1);  send(OP_LDS, 5'd5, 5'd0, 3'd0, 22'h00BEEF);
        tick(3);

        // Reset while the second jmp word is pending discards it
        out_ready = 1'b0;
        push_word(16'h940C, 1'b0);
        send(OP_JMP, 5'd0, 5'd0, 3'd0, 22'h001234);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        rst_n = 1'b0;
        tick(1);
        chk("midrst_valid", 32'(out_valid_a), 32'd0);
        chk("midrst_addr", 32'(out_addr_a), 32'(A_BASE));
        chk("midrst_b_addr", 32'(out_addr_b), 32'(B_BASE));
        chk("midrst_ready", 32'(in_ready_a), 32'd0);
        rst_n = 1'b1;
        exp_a = 16'(A_BASE);
        exp_b = 4'(B_BASE);
        tick(1);
        chk("midrst_ready_after", 32'(in_ready_a), 32'd1);
        out_ready = 1'b1;
        push_word(16'h0000, 1'b1);
        send(OP_NOP, 5'd0, 5'd0, 3'd0, 22'd0);
        push_word(16'h0C12, 1'b1);
        send(OP_ADD, 5'd1, 5'd2, 3'd0, 22'd0);
        tick(4);

        chk("a_words_drained", 32'(qa.size()), 32'd0);
        chk("b_words_drained", 32'(qb.size()), 32'd0);
        chk("a_errs_drained", 32'(ea.size()), 32'd0);
        chk("b_errs_drained", 32'(eb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
